// File: rtl/mem_bridge_pkg.sv
// Shared types and lane helpers for the CPU-to-SRAM data-memory bridge.
package mem_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } state_e;

    function automatic logic [BE_W-1:0] byte_en(input size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] repl_wdata(input size_e size, input logic [DATA_W-1:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// SRAM-side request/response bus between the bridge (master) and memory (slave).
interface mem_bridge_if;
    import mem_bridge_pkg::*;

    logic              b_req;
    logic              b_gnt;
    logic [ADDR_W-1:0] b_addr;
    logic              b_we;
    logic [BE_W-1:0]   b_be;
    logic [DATA_W-1:0] b_wdata;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    modport master (
        output b_req, b_addr, b_we, b_be, b_wdata,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  b_req, b_addr, b_we, b_be, b_wdata,
        output b_gnt, b_rvalid, b_rdata
    );

endinterface

// File: rtl/mem_bridge_load_align.sv
// Load lane select plus sign/zero extension of SRAM read data.
module mem_bridge_load_align
    import mem_bridge_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        off,
    input  size_e             size,
    input  logic              uns,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = rdata[{off[1], 4'b0000} +: 16];
        result = rdata;
        case (size)
            SZ_BYTE: result = uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_HALF: result = uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// CPU load/store port to single-ported SRAM bus bridge with transaction watchdog.
// Optional misalignment trap: define MEM_BRIDGE_MISALIGN_CHECK_EN.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_valid,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [1:0]        c_size,
    input  logic              c_wr,
    input  logic              c_unsigned,
    output logic              c_ready,
    output logic              c_err,
    output logic [DATA_W-1:0] c_rdata,
    output logic              busy,
    mem_bridge_if.master      bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_q;
    logic [1:0]        off_q;
    size_e             size_q;
    logic              uns_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] load_data;
    logic              req_bad;
    logic              wd_hit;

    mem_bridge_load_align u_load_align (
        .rdata  (bus.b_rdata),
        .off    (off_q),
        .size   (size_q),
        .uns    (uns_q),
        .result (load_data)
    );

    // Requests rejected without touching the bus
    always_comb begin
        req_bad = (size_e'(c_size) == SZ_ILL);
`ifdef MEM_BRIDGE_MISALIGN_CHECK_EN
        req_bad = req_bad | misaligned(size_e'(c_size), c_addr[1:0]);
`endif
    end

    // Counter is >= TIMEOUT-1 in the last allowed REQ/RESP cycle
    assign wd_hit = (TIMEOUT != 0) && (cnt_q >= CNT_W'(TIMEOUT - 1));

    assign c_ready   = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign bus.b_req = (state_q == ST_REQ);
    assign c_err     = err_q;
    assign c_rdata   = rdata_q;

    // Grant/rvalid win over a watchdog expiry in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            off_q       <= 2'b00;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            bus.b_addr  <= '0;
            bus.b_we    <= 1'b0;
            bus.b_be    <= '0;
            bus.b_wdata <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (c_valid) begin
                        off_q   <= c_addr[1:0];
                        size_q  <= size_e'(c_size);
                        uns_q   <= c_unsigned;
                        rdata_q <= '0;
                        cnt_q   <= '0;
                        if (req_bad) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            err_q       <= 1'b0;
                            state_q     <= ST_REQ;
                            bus.b_addr  <= {c_addr[ADDR_W-1:2], 2'b00};
                            bus.b_we    <= c_wr;
                            bus.b_be    <= byte_en(size_e'(c_size), c_addr[1:0]);
                            bus.b_wdata <= repl_wdata(size_e'(c_size), c_wdata);
                        end
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.b_gnt) begin
                        state_q <= bus.b_we ? ST_DONE : ST_RESP;
                    end else if (wd_hit) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_RESP: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.b_rvalid) begin
                        rdata_q <= load_data;
                        state_q <= ST_DONE;
                    end else if (wd_hit) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed, table-driven bench for mem_bridge plus watchdog and reset sequences.
module tb_mem_bridge;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        wr;
        logic        uns;
        int          gnt_wait;
        int          rv_wait;
        logic [31:0] rdata;
        int          lat;
        int          reqc;
        logic        err;
        logic [31:0] exp_rdata;
        logic [31:0] b_addr;
        logic [3:0]  be;
        logic [31:0] b_wdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        c_valid = 1'b0;
    logic        c_valid2 = 1'b0;
    logic [31:0] c_addr = '0;
    logic [31:0] c_wdata = '0;
    logic [1:0]  c_size = '0;
    logic        c_wr = 1'b0;
    logic        c_unsigned = 1'b0;
    logic        c_ready, c_err, busy;
    logic        c_ready2, c_err2, busy2;
    logic [31:0] c_rdata, c_rdata2;
    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        vecs[$];

    mem_bridge_if bus ();
    mem_bridge_if bus2 ();

    mem_bridge dut (
        .clk(clk), .rst(rst), .c_valid(c_valid), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_size(c_size), .c_wr(c_wr), .c_unsigned(c_unsigned), .c_ready(c_ready),
        .c_err(c_err), .c_rdata(c_rdata), .busy(busy), .bus(bus)
    );

    mem_bridge #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .c_valid(c_valid2), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_size(c_size), .c_wr(c_wr), .c_unsigned(c_unsigned), .c_ready(c_ready2),
        .c_err(c_err2), .c_rdata(c_rdata2), .busy(busy2), .bus(bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and act as a memory with the vector's grant/rvalid delays
    task automatic run_vec(input int idx, input vec_t v);
        int          lat, reqc, resp_n;
        bit          granted, seen, done;
        logic [31:0] o_addr, o_wdata, o_rdata;
        logic [3:0]  o_be;
        logic        o_we, o_err;
        lat = 0; reqc = 0; resp_n = 0;
        granted = 1'b0; seen = 1'b0; done = 1'b0;
        o_addr = '0; o_wdata = '0; o_rdata = '0; o_be = '0; o_we = 1'b0; o_err = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'h0);
        check($sformatf("v%0d_idle_ready", idx), 32'(c_ready), 32'h0);
        c_valid = 1'b1; c_addr = v.addr; c_wdata = v.wdata;
        c_size = v.size; c_wr = v.wr; c_unsigned = v.uns;
        while (!done && lat < 64) begin
            @(negedge clk);
            lat++;
            c_valid = 1'b0; bus.b_gnt = 1'b0; bus.b_rvalid = 1'b0; bus.b_rdata = 32'h5A5A_5A5A;
            if (c_ready) begin
                done = 1'b1; o_err = c_err; o_rdata = c_rdata;
            end else if (bus.b_req) begin
                if (!seen) begin
                    o_addr = bus.b_addr; o_wdata = bus.b_wdata; o_be = bus.b_be; o_we = bus.b_we;
                    seen = 1'b1;
                end
                if (reqc == v.gnt_wait) begin
                    bus.b_gnt = 1'b1;
                    granted = !bus.b_we;
                end
                reqc++;
            end else if (granted) begin
                if (resp_n == v.rv_wait) begin
                    bus.b_rvalid = 1'b1; bus.b_rdata = v.rdata;
                end
                resp_n++;
            end
        end
        check($sformatf("v%0d_done", idx), 32'(done), 32'h1);
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d_req_cycles", idx), 32'(reqc), 32'(v.reqc));
        check($sformatf("v%0d_err", idx), 32'(o_err), 32'(v.err));
        if (!v.wr && !v.err) check($sformatf("v%0d_rdata", idx), o_rdata, v.exp_rdata);
        if (v.reqc > 0) begin
            check($sformatf("v%0d_b_addr", idx), o_addr, v.b_addr);
            check($sformatf("v%0d_b_be", idx), 32'(o_be), 32'(v.be));
            check($sformatf("v%0d_b_wdata", idx), o_wdata, v.b_wdata);
            check($sformatf("v%0d_b_we", idx), 32'(o_we), 32'(v.wr));
        end
    endtask

    initial begin
        vec_t v;
        int   pulses, n, reqc;
        bit   done;

        // addr wdata size wr uns gntw rvw rdata lat reqc err exp_rdata b_addr be b_wdata
        v = '{32'h1003, 32'hAB, 2'b00, 1'b1, 1'b0, 0, 0, 32'h0, 2, 1, 1'b0, 32'h0, 32'h1000, 4'b1000, 32'hABAB_ABAB}; vecs.push_back(v);
        v = '{32'h2002, 32'h0, 2'b01, 1'b0, 1'b0, 0, 0, 32'h8001_1234, 3, 1, 1'b0, 32'hFFFF_8001, 32'h2000, 4'b1100, 32'h0}; vecs.push_back(v);
        v = '{32'h2002, 32'h0, 2'b01, 1'b0, 1'b1, 0, 0, 32'h8001_1234, 3, 1, 1'b0, 32'h0000_8001, 32'h2000, 4'b1100, 32'h0}; vecs.push_back(v);
        v = '{32'h3000, 32'h0, 2'b10, 1'b0, 1'b0, 3, 2, 32'hDEAD_BEEF, 8, 4, 1'b0, 32'hDEAD_BEEF, 32'h3000, 4'b1111, 32'h0}; vecs.push_back(v);
        v = '{32'h0102, 32'h1234_5678, 2'b01, 1'b1, 1'b0, 0, 0, 32'h0, 2, 1, 1'b0, 32'h0, 32'h0100, 4'b1100, 32'h5678_5678}; vecs.push_back(v);
        v = '{32'h0011, 32'h0, 2'b00, 1'b0, 1'b0, 0, 0, 32'h0000_8000, 3, 1, 1'b0, 32'hFFFF_FF80, 32'h0010, 4'b0010, 32'h0}; vecs.push_back(v);
        v = '{32'h0012, 32'h0, 2'b00, 1'b0, 1'b1, 0, 0, 32'h00A5_0000, 3, 1, 1'b0, 32'h0000_00A5, 32'h0010, 4'b0100, 32'h0}; vecs.push_back(v);
        v = '{32'h0004, 32'hCAFE_F00D, 2'b10, 1'b1, 1'b0, 1, 0, 32'h0, 3, 2, 1'b0, 32'h0, 32'h0004, 4'b1111, 32'hCAFE_F00D}; vecs.push_back(v);
        v = '{32'h0000, 32'h0, 2'b11, 1'b0, 1'b0, 0, 0, 32'h0, 1, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0}; vecs.push_back(v);
`ifdef MEM_BRIDGE_MISALIGN_CHECK_EN
        v = '{32'h1002, 32'h0, 2'b10, 1'b0, 1'b0, 0, 0, 32'h1122_3344, 1, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0}; vecs.push_back(v);
        v = '{32'h2001, 32'hBEEF, 2'b01, 1'b1, 1'b0, 0, 0, 32'h0, 1, 0, 1'b1, 32'h0, 32'h0, 4'b0000, 32'h0}; vecs.push_back(v);
`else
        v = '{32'h1002, 32'h0, 2'b10, 1'b0, 1'b0, 0, 0, 32'h1122_3344, 3, 1, 1'b0, 32'h1122_3344, 32'h1000, 4'b1111, 32'h0}; vecs.push_back(v);
        v = '{32'h2001, 32'hBEEF, 2'b01, 1'b1, 1'b0, 0, 0, 32'h0, 2, 1, 1'b0, 32'h0, 32'h2000, 4'b0011, 32'hBEEF_BEEF}; vecs.push_back(v);
`endif

        bus.b_gnt = 1'b0; bus.b_rvalid = 1'b0; bus.b_rdata = '0;
        bus2.b_gnt = 1'b0; bus2.b_rvalid = 1'b0; bus2.b_rdata = '0;

        // Reset state
        @(negedge clk);
        check("rst_c_ready", 32'(c_ready), 32'h0);
        check("rst_c_err", 32'(c_err), 32'h0);
        check("rst_c_rdata", c_rdata, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_b_req", 32'(bus.b_req), 32'h0);
        check("rst_b_we", 32'(bus.b_we), 32'h0);
        check("rst_b_be", 32'(bus.b_be), 32'h0);
        check("rst_b_addr", bus.b_addr, 32'h0);
        check("rst_b_wdata", bus.b_wdata, 32'h0);
        check("rst_busy2", 32'(busy2), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Watchdog on the TIMEOUT=4 instance: grant never arrives
        @(negedge clk);
        c_valid2 = 1'b1; c_addr = 32'h40; c_size = 2'b10; c_wr = 1'b0; c_unsigned = 1'b0;
        n = 0; reqc = 0; done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            c_valid2 = 1'b0;
            if (c_ready2) done = 1'b1;
            else if (bus2.b_req) reqc++;
        end
        check("to_done", 32'(done), 32'h1);
        check("to_latency", 32'(n), 32'd5);
        check("to_req_cycles", 32'(reqc), 32'd4);
        check("to_b_req_dropped", 32'(bus2.b_req), 32'h0);
        check("to_err", 32'(c_err2), 32'h1);
        check("to_rdata", c_rdata2, 32'h0);
        @(negedge clk);
        bus2.b_rvalid = 1'b1; bus2.b_rdata = 32'hFFFF_FFFF;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus2.b_rvalid = 1'b0;
            if (c_ready2) pulses++;
        end
        check("to_spurious_pulses", 32'(pulses), 32'h0);
        check("to_busy_after", 32'(busy2), 32'h0);

        // Reset asserted while the main instance waits in RESP
        @(negedge clk);
        c_valid = 1'b1; c_addr = 32'h50; c_size = 2'b10; c_wr = 1'b0; c_unsigned = 1'b0;
        @(negedge clk);
        c_valid = 1'b0;
        check("rr_b_req", 32'(bus.b_req), 32'h1);
        bus.b_gnt = 1'b1;
        @(negedge clk);
        bus.b_gnt = 1'b0;
        check("rr_busy_resp", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rr_busy_async", 32'(busy), 32'h0);
        check("rr_b_req_async", 32'(bus.b_req), 32'h0);
        check("rr_ready_async", 32'(c_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.b_rvalid = 1'b1; bus.b_rdata = 32'h1234_5678;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.b_rvalid = 1'b0;
            if (c_ready) pulses++;
        end
        check("rr_no_ready", 32'(pulses), 32'h0);
        run_vec(100, vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Data-memory bridge between the two-stage CPU's load/store port and the single-ported SRAM bus. It accepts one byte/half/word request at a time, drives a req/gnt address phase with lane-replicated write data and byte enables, and waits for b_rvalid on reads. It then returns aligned, sign- or zero-extended load data to the CPU with a one-cycle completion pulse. A watchdog counter bounds every bus transaction.

## Interface
- TIMEOUT, 255: max cycles spent in REQ+RESP before abort; 0 disables the watchdog.
- clk  in  1  clock, rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- c_valid  in  1  request strobe, sampled only in IDLE.
- c_addr  in  32  byte address.
- c_wdata  in  32  store data, LSB-justified.
- c_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- c_wr  in  1  1 store, 0 load.
- c_unsigned  in  1  load zero-extend (1) or sign-extend (0).
- c_ready  out  1  one-cycle completion pulse.
- c_err  out  1  qualified by c_ready: misaligned, illegal size, or timeout.
- c_rdata  out  32  load result, valid with c_ready.
- busy  out  1  high in any state but IDLE.
- b_req  out  1  bus request, held until b_gnt.
- b_gnt  in  1  address-phase accept.
- b_addr  out  32  word address, {c_addr[31:2],2'b00}.
- b_we  out  1  write enable.
- b_be  out  4  byte enables.
- b_wdata  out  32  lane-replicated store data.
- b_rvalid  in  1  read data valid.
- b_rdata  in  32  read data.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: c_valid=1 captures addr, size, wr, unsigned, and wdata into registers.
  - Illegal size, or misaligned access with the check compiled in: go to DONE with the error flag set. No bus access.
  - Otherwise go to REQ.
- REQ: b_req=1, bus outputs driven from the captured registers.
  - b_gnt & b_we: go to DONE.
  - b_gnt & ~b_we: go to RESP.
- RESP: b_rvalid=1 latches the extracted load data and goes to DONE.
- DONE: c_ready=1 for one cycle, then IDLE.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- b_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extract:
  - byte lane = b_rdata[8*addr[1:0]+:8]
  - half lane = b_rdata[16*addr[1]+:16]
  - Extend per c_unsigned; word passes through.
- Watchdog: counter cleared on entry to REQ and incremented each cycle in REQ/RESP. When it reaches TIMEOUT: drop b_req, go to DONE with c_err=1, c_rdata=0.
- c_valid while busy is ignored; the request is dropped and the CPU must re-issue.
- b_rvalid outside RESP and b_gnt outside REQ are ignored. This covers a late response after a timeout.

## Timing
- Reset values: c_ready=0, c_err=0, c_rdata=0, busy=0, b_req=0, b_we=0, b_be=0, b_addr=0, b_wdata=0, FSM=IDLE, counter=0.
- All outputs are registered or decoded from registered state. There are no combinational in-to-out paths.
- Store, zero-wait: c_valid at T0, b_req at T1, b_gnt at T1, c_ready at T2.
- Load, zero-wait: c_valid at T0, b_req/b_gnt at T1, b_rvalid at T2, c_ready with c_rdata at T3.
- Error without bus access: c_valid at T0, c_ready with c_err at T1, b_req stays low.
- Back-to-back: the next c_valid is accepted earliest in the cycle c_ready is high + 1. busy is 0 in that cycle.
- Reset asserted mid-transaction: b_req and busy drop asynchronously and all state returns to IDLE. No c_ready is generated for the aborted request.

## Configuration
- MEM_BRIDGE_MISALIGN_CHECK_EN defined:
  - half with addr[0]=1, or word with addr[1:0]!=0, completes at T1 with c_err=1.
  - No bus access is made.
- Not defined:
  - No check is made.
  - half ignores addr[0]; word ignores addr[1:0]. Both execute normally with c_err=0.

## Structure
- Package mem_bridge_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL
  - FSM state enum
  - byte-enable and write-replication functions
- One sub-module, load_align: combinational lane select plus sign/zero extension. Inputs b_rdata, addr[1:0], size, unsigned; output 32-bit result.

## Test plan
- Store byte, c_addr=0x1003, c_wdata=0xAB, gnt same cycle -> b_addr=0x1000, b_be=4'b1000, b_wdata=0xABABABAB, b_we=1, c_ready at T2.
- Load half signed, addr=0x2002, b_rdata=0x8001_1234, rvalid at T2 -> c_rdata=0xFFFF8001 at T3. Same with c_unsigned=1 -> 0x00008001.
- Load word with b_gnt held low 3 cycles, then rvalid after 2 more -> b_req stable until gnt, c_ready exactly once, c_rdata = b_rdata.
- TIMEOUT=4, never grant -> b_req drops and c_ready+c_err fire at the 4th REQ cycle, c_rdata=0. A later spurious b_rvalid causes no pulse.
- Word load at 0x1002: with macro -> c_err at T1, b_req never high. Without macro -> b_addr=0x1000, normal completion, c_err=0. c_size=11 -> c_err at T1 in both builds.
- Reset low during RESP -> b_req/busy 0 immediately, no c_ready. After release, a fresh load completes normally.
